// File: rtl/control_pkg.sv
// control_pkg: shared state encoding and mux-select encodings for control_unit.
// Contents: state_t (FSM states, exported on state_dbg), alu_op_t (ALU-class
// instruction latched at DECODE), and the op1/op2/immediate/write-address selects.
package control_pkg;

  typedef enum logic [3:0] {
    ST_RESET       = 4'd0,
    ST_FETCH       = 4'd1,
    ST_DECODE      = 4'd2,
    ST_BRANCH      = 4'd3,
    ST_BRZ         = 4'd4,
    ST_ALU_OP      = 4'd5,
    ST_MOV_LOAD    = 4'd6,
    ST_MOV_STEP    = 4'd7,
    ST_MOV_WAIT    = 4'd8,
    ST_PAUSE_START = 4'd9,
    ST_PAUSE_WAIT  = 4'd10,
    ST_ADVANCE     = 4'd11
  } state_t;

  // Single-cycle register-file instructions, captured at DECODE so the
  // ALU_OP outputs depend only on registered state.
  typedef enum logic [3:0] {
    ALU_NONE   = 4'd0,
    ALU_ADDI   = 4'd1,
    ALU_SUBI   = 4'd2,
    ALU_SR0    = 4'd3,
    ALU_SRH0   = 4'd4,
    ALU_CLR    = 4'd5,
    ALU_MOVA   = 4'd6,
    ALU_MOVR   = 4'd7,
    ALU_MOVRHS = 4'd8
  } alu_op_t;

  localparam logic [1:0] OP1_PC  = 2'd0;
  localparam logic [1:0] OP1_REG = 2'd1;
  localparam logic [1:0] OP1_R0  = 2'd2;
  localparam logic [1:0] OP1_POS = 2'd3;

  localparam logic [1:0] OP2_REG  = 2'd0;
  localparam logic [1:0] OP2_IMM  = 2'd1;
  localparam logic [1:0] OP2_ONE  = 2'd2;
  localparam logic [1:0] OP2_ZERO = 2'd3;

  localparam logic [1:0] IMM_BRANCH = 2'd0;
  localparam logic [1:0] IMM_ARITH  = 2'd1;
  localparam logic [1:0] IMM_NIBBLE = 2'd2;
  localparam logic [1:0] IMM_ZERO   = 2'd3;

  localparam logic [1:0] WA_FIELD0 = 2'd0;
  localparam logic [1:0] WA_FIELD1 = 2'd1;
  localparam logic [1:0] WA_POS    = 2'd2;
  localparam logic [1:0] WA_R0     = 2'd3;

  // alu_add_sub polarity
  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

endpackage

// File: rtl/control_unit_settle_timer.sv
// settle_timer: counts cycles spent in FETCH while the synchronous ROM settles.
// Ports: clk, reset_n (async active-low), active_i (FSM is in FETCH),
//        done_o (high in the last FETCH cycle; combinational from the count).
module settle_timer #(
  parameter int unsigned CYCLES = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic active_i,
  output logic done_o
);

  // A zero setting still spends one cycle in FETCH.
  localparam int unsigned N = (CYCLES < 1) ? 1 : CYCLES;
  localparam int unsigned W = (N < 2) ? 1 : $clog2(N);
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign done_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (!active_i) begin
      cnt_d = '0;
    end else if (!done_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: Moore FSM sequencing fetch/decode/execute of a small
// motion-control ISA (branches, ALU ops, stepped position moves, pauses).
// Ports: clk, reset_n; decoded instruction flags and datapath status in;
// datapath strobes, 2-bit mux selects and state_dbg (current state) out.
module control_unit
  import control_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter bit          STEP_SIGNED   = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       br,
  input  logic       brz,
  input  logic       addi,
  input  logic       subi,
  input  logic       sr0,
  input  logic       srh0,
  input  logic       clr,
  input  logic       mov,
  input  logic       mova,
  input  logic       movr,
  input  logic       movrhs,
  input  logic       pause,
  input  logic       delay_done,
  input  logic       temp_is_positive,
  input  logic       temp_is_negative,
  input  logic       temp_is_zero,
  input  logic       register0_is_zero,
  output logic       write_reg_file,
  output logic       result_mux_select,
  output logic       start_delay_counter,
  output logic       enable_delay_counter,
  output logic       commit_branch,
  output logic       increment_pc,
  output logic       alu_add_sub,
  output logic       alu_set_low,
  output logic       alu_set_high,
  output logic       load_temp,
  output logic       increment_temp,
  output logic       decrement_temp,
  output logic [1:0] op1_mux_select,
  output logic [1:0] op2_mux_select,
  output logic [1:0] select_immediate,
  output logic [1:0] select_write_address,
  output logic [3:0] state_dbg
);

  state_t  state_q, state_d;
  alu_op_t alu_op_q, alu_op_d;
  logic    settle_done;
  logic    step_back;

  settle_timer #(.CYCLES(SETTLE_CYCLES)) u_settle (
    .clk      (clk),
    .reset_n  (reset_n),
    .active_i (state_q == ST_FETCH),
    .done_o   (settle_done)
  );

  // Move backwards only for a signed step count that is actually negative;
  // in unsigned mode every non-zero count steps forward.
  assign step_back = STEP_SIGNED && temp_is_negative && !temp_is_positive;

  assign state_dbg = state_q;

  always_comb begin
    state_d              = state_q;
    alu_op_d             = alu_op_q;
    write_reg_file       = 1'b0;
    result_mux_select    = 1'b0;
    start_delay_counter  = 1'b0;
    enable_delay_counter = 1'b0;
    commit_branch        = 1'b0;
    increment_pc         = 1'b0;
    alu_add_sub          = ALU_ADD;
    alu_set_low          = 1'b0;
    alu_set_high         = 1'b0;
    load_temp            = 1'b0;
    increment_temp       = 1'b0;
    decrement_temp       = 1'b0;
    op1_mux_select       = OP1_PC;
    op2_mux_select       = OP2_REG;
    select_immediate     = IMM_BRANCH;
    select_write_address = WA_FIELD0;

    case (state_q)
      ST_RESET: state_d = ST_FETCH;

      ST_FETCH: if (settle_done) state_d = ST_DECODE;

      ST_DECODE: begin
        alu_op_d = ALU_NONE;
        if (br)          state_d = ST_BRANCH;
        else if (brz)    state_d = ST_BRZ;
        else if (mov)    state_d = ST_MOV_LOAD;
        else if (pause)  state_d = ST_PAUSE_START;
        else begin
          state_d = ST_ALU_OP;
          if (addi)        alu_op_d = ALU_ADDI;
          else if (subi)   alu_op_d = ALU_SUBI;
          else if (sr0)    alu_op_d = ALU_SR0;
          else if (srh0)   alu_op_d = ALU_SRH0;
          else if (clr)    alu_op_d = ALU_CLR;
          else if (mova)   alu_op_d = ALU_MOVA;
          else if (movr)   alu_op_d = ALU_MOVR;
          else if (movrhs) alu_op_d = ALU_MOVRHS;
          else             state_d  = ST_ADVANCE;
        end
      end

      ST_BRANCH: begin
        commit_branch    = 1'b1;
        op1_mux_select   = OP1_PC;
        op2_mux_select   = OP2_IMM;
        select_immediate = IMM_BRANCH;
        alu_add_sub      = ALU_ADD;
        state_d          = ST_FETCH;
      end

      ST_BRZ: begin
        if (register0_is_zero) begin
          commit_branch    = 1'b1;
          op1_mux_select   = OP1_PC;
          op2_mux_select   = OP2_IMM;
          select_immediate = IMM_BRANCH;
          alu_add_sub      = ALU_ADD;
          state_d          = ST_FETCH;
        end else begin
          state_d = ST_ADVANCE;
        end
      end

      ST_ALU_OP: begin
        write_reg_file = 1'b1;
        state_d        = ST_ADVANCE;
        case (alu_op_q)
          ALU_ADDI, ALU_SUBI: begin
            op1_mux_select       = OP1_REG;
            op2_mux_select       = OP2_IMM;
            select_immediate     = IMM_ARITH;
            alu_add_sub          = (alu_op_q == ALU_SUBI) ? ALU_SUB : ALU_ADD;
            select_write_address = WA_FIELD1;
          end
          ALU_SR0, ALU_SRH0: begin
            alu_set_low          = (alu_op_q == ALU_SR0);
            alu_set_high         = (alu_op_q == ALU_SRH0);
            op2_mux_select       = OP2_IMM;
            select_immediate     = IMM_NIBBLE;
            select_write_address = WA_R0;
          end
          ALU_CLR: begin
            // Loading both nibbles from a zero immediate clears the register.
            alu_set_low          = 1'b1;
            alu_set_high         = 1'b1;
            op2_mux_select       = OP2_IMM;
            select_immediate     = IMM_ZERO;
            select_write_address = WA_FIELD0;
          end
          ALU_MOVA: begin
            op1_mux_select       = OP1_R0;
            op2_mux_select       = OP2_ZERO;
            select_write_address = WA_FIELD0;
          end
          ALU_MOVR: begin
            op1_mux_select       = OP1_REG;
            op2_mux_select       = OP2_ZERO;
            select_write_address = WA_FIELD0;
          end
          ALU_MOVRHS: begin
            op1_mux_select       = OP1_POS;
            op2_mux_select       = OP2_ZERO;
            select_write_address = WA_FIELD1;
          end
          default: write_reg_file = 1'b0;
        endcase
      end

      ST_MOV_LOAD: begin
        load_temp = 1'b1;
        state_d   = ST_MOV_STEP;
      end

      ST_MOV_STEP: begin
        if (temp_is_zero) begin
          state_d = ST_ADVANCE;
        end else begin
          // One position step per visit; temp counts toward zero and the
          // delay counter paces the next step.
          write_reg_file       = 1'b1;
          op1_mux_select       = OP1_POS;
          op2_mux_select       = OP2_ONE;
          select_write_address = WA_POS;
          alu_add_sub          = step_back ? ALU_SUB : ALU_ADD;
          increment_temp       = step_back;
          decrement_temp       = !step_back;
          start_delay_counter  = 1'b1;
          state_d              = ST_MOV_WAIT;
        end
      end

      ST_MOV_WAIT: begin
        enable_delay_counter = !delay_done;
        if (delay_done) state_d = ST_MOV_STEP;
      end

      ST_PAUSE_START: begin
        start_delay_counter = 1'b1;
        state_d             = ST_PAUSE_WAIT;
      end

      ST_PAUSE_WAIT: begin
        enable_delay_counter = !delay_done;
        if (delay_done) state_d = ST_ADVANCE;
      end

      ST_ADVANCE: begin
        increment_pc = 1'b1;
        state_d      = ST_FETCH;
      end

      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_RESET;
      alu_op_q <= ALU_NONE;
    end else begin
      state_q  <= state_d;
      alu_op_q <= alu_op_d;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;
  import control_pkg::*;

  localparam int S = 1;

  logic clk = 1'b0;
  logic reset_n;
  logic br, brz, addi, subi, sr0, srh0, clr, mov, mova, movr, movrhs, pause;
  logic delay_done, temp_is_positive, temp_is_negative, temp_is_zero, register0_is_zero;
  logic write_reg_file, result_mux_select, start_delay_counter, enable_delay_counter;
  logic commit_branch, increment_pc, alu_add_sub, alu_set_low, alu_set_high;
  logic load_temp, increment_temp, decrement_temp;
  logic [1:0] op1_mux_select, op2_mux_select, select_immediate, select_write_address;
  logic [3:0] state_dbg;
  logic [23:0] outs;

  always #5 clk = ~clk;

  control_unit #(.SETTLE_CYCLES(S), .STEP_SIGNED(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .br(br), .brz(brz), .addi(addi), .subi(subi), .sr0(sr0), .srh0(srh0), .clr(clr),
    .mov(mov), .mova(mova), .movr(movr), .movrhs(movrhs), .pause(pause),
    .delay_done(delay_done), .temp_is_positive(temp_is_positive),
    .temp_is_negative(temp_is_negative), .temp_is_zero(temp_is_zero),
    .register0_is_zero(register0_is_zero),
    .write_reg_file(write_reg_file), .result_mux_select(result_mux_select),
    .start_delay_counter(start_delay_counter), .enable_delay_counter(enable_delay_counter),
    .commit_branch(commit_branch), .increment_pc(increment_pc), .alu_add_sub(alu_add_sub),
    .alu_set_low(alu_set_low), .alu_set_high(alu_set_high), .load_temp(load_temp),
    .increment_temp(increment_temp), .decrement_temp(decrement_temp),
    .op1_mux_select(op1_mux_select), .op2_mux_select(op2_mux_select),
    .select_immediate(select_immediate), .select_write_address(select_write_address),
    .state_dbg(state_dbg)
  );

  assign outs = {write_reg_file, result_mux_select, start_delay_counter, enable_delay_counter,
                 commit_branch, increment_pc, alu_add_sub, alu_set_low, alu_set_high,
                 load_temp, increment_temp, decrement_temp, op1_mux_select, op2_mux_select,
                 select_immediate, select_write_address, state_dbg};

  int tests = 0;
  int fails = 0;

  // Environment model: temp register, delay counter, register 0 status.
  int temp    = 0;
  int dly_cnt = 0;   // delay_done is high while this is 0
  int dly_len = 1;   // delay_done rises dly_len cycles after a start
  int tload   = 0;   // value the temp register takes on load_temp
  bit r0z     = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    temp_is_zero      = (temp == 0);
    temp_is_positive  = (temp > 0);
    temp_is_negative  = (temp < 0);
    delay_done        = (dly_cnt == 0);
    register0_is_zero = r0z;
  endtask

  // Flag bit i is the i-th instruction in dispatch priority order.
  task automatic set_flags(input logic [11:0] f);
    {movrhs, movr, mova, clr, srh0, sr0, subi, addi, pause, mov, brz, br} = f;
  endtask

  task automatic model_update();
    if (load_temp) temp = tload;
    if (decrement_temp) temp--;
    if (increment_temp) temp++;
    if (start_delay_counter) dly_cnt = dly_len - 1;
    else if (dly_cnt > 0) dly_cnt--;
  endtask

  function automatic int kind_of(input logic [11:0] f);
    for (int i = 0; i < 12; i++) if (f[i]) return i;
    return 12;
  endfunction

  // Executes one instruction starting in its first FETCH cycle (called at
  // posedge+1) and returns at posedge+1 of the following FETCH.
  task automatic run_instr(input string tag, input logic [11:0] f, input bit rz,
                           input int tl, input int dl);
    int k, n, e_cyc, e_commit, e_inc, e_wr, e_start, e_en, e_dec, e_incT, e_load;
    int cyc, c_commit, c_inc, c_wr, c_start, c_en, c_dec, c_incT, c_load;
    bit done;
    logic [1:0] w_op1, w_op2, w_imm, w_wa, b_op1, b_op2, b_imm;
    logic w_as, w_lo, w_hi, b_as;
    set_flags(f); r0z = rz; tload = tl; dly_len = dl;
    drive_inputs();
    k = kind_of(f);
    n = (tl < 0) ? -tl : tl;
    e_commit = 0; e_inc = 1; e_wr = 0; e_start = 0; e_en = 0; e_dec = 0; e_incT = 0; e_load = 0;
    case (k)
      0: begin e_cyc = S + 2; e_commit = 1; e_inc = 0; end
      1: if (rz) begin e_cyc = S + 2; e_commit = 1; e_inc = 0; end else e_cyc = S + 3;
      2: begin
        e_cyc = S + 4 + n * (1 + dl); e_wr = n; e_start = n; e_en = n * (dl - 1); e_load = 1;
        if (tl > 0) e_dec = n; else e_incT = n;
      end
      3: begin e_cyc = S + 3 + dl; e_start = 1; e_en = dl - 1; end
      12: e_cyc = S + 2;
      default: begin e_cyc = S + 3; e_wr = 1; end
    endcase
    cyc = 0; done = 0;
    c_commit = 0; c_inc = 0; c_wr = 0; c_start = 0; c_en = 0; c_dec = 0; c_incT = 0; c_load = 0;
    {w_op1, w_op2, w_imm, w_wa, w_as, w_lo, w_hi} = '0;
    {b_op1, b_op2, b_imm, b_as} = '1;
    while (!done && cyc < 300) begin
      @(negedge clk);
      if (cyc == 0) chk({tag, ".fetch"}, state_dbg, ST_FETCH);
      c_commit += commit_branch; c_inc += increment_pc; c_wr += write_reg_file;
      c_start += start_delay_counter; c_en += enable_delay_counter;
      c_dec += decrement_temp; c_incT += increment_temp; c_load += load_temp;
      if (write_reg_file) begin
        {w_op1, w_op2, w_imm, w_wa} = {op1_mux_select, op2_mux_select, select_immediate, select_write_address};
        {w_as, w_lo, w_hi} = {alu_add_sub, alu_set_low, alu_set_high};
        if (k == 2) begin
          chk({tag, ".step_op"}, {op1_mux_select, op2_mux_select, select_write_address},
              {OP1_POS, OP2_ONE, WA_POS});
          chk({tag, ".step_dir"}, {alu_add_sub, decrement_temp, increment_temp},
              {temp < 0, temp > 0, temp < 0});
        end
      end
      if (commit_branch) begin
        {b_op1, b_op2, b_imm, b_as} = {op1_mux_select, op2_mux_select, select_immediate, alu_add_sub};
      end
      if (commit_branch || increment_pc) begin
        chk({tag, ".excl"}, commit_branch & increment_pc, 1'b0);
        done = 1;
      end
      model_update();
      cyc++;
      @(posedge clk); #1;
      drive_inputs();
    end
    chk({tag, ".finished"}, done, 1'b1);
    chk({tag, ".cycles"}, cyc, e_cyc);
    chk({tag, ".commit"}, c_commit, e_commit);
    chk({tag, ".incpc"}, c_inc, e_inc);
    chk({tag, ".writes"}, c_wr, e_wr);
    chk({tag, ".starts"}, c_start, e_start);
    chk({tag, ".enables"}, c_en, e_en);
    chk({tag, ".tempdec"}, c_dec, e_dec);
    chk({tag, ".tempinc"}, c_incT, e_incT);
    chk({tag, ".load"}, c_load, e_load);
    if (e_commit == 1) chk({tag, ".br_sel"}, {b_op1, b_op2, b_imm, b_as}, {OP1_PC, OP2_IMM, IMM_BRANCH, ALU_ADD});
    case (k)
      4, 5: chk({tag, ".alu"}, {w_op1, w_op2, w_wa, w_as, w_lo, w_hi},
                {OP1_REG, OP2_IMM, WA_FIELD1, (k == 5), 1'b0, 1'b0});
      6, 7: chk({tag, ".alu"}, {w_op2, w_wa, w_lo, w_hi}, {OP2_IMM, WA_R0, (k == 6), (k == 7)});
      8:    chk({tag, ".alu"}, {w_imm, w_wa, w_lo, w_hi}, {IMM_ZERO, WA_FIELD0, 1'b1, 1'b1});
      9:    chk({tag, ".alu"}, {w_op1, w_op2, w_wa, w_as}, {OP1_R0, OP2_ZERO, WA_FIELD0, ALU_ADD});
      10:   chk({tag, ".alu"}, {w_op1, w_op2, w_wa, w_as}, {OP1_REG, OP2_ZERO, WA_FIELD0, ALU_ADD});
      11:   chk({tag, ".alu"}, {w_op1, w_op2, w_wa, w_as}, {OP1_POS, OP2_ZERO, WA_FIELD1, ALU_ADD});
      default: ;
    endcase
  endtask

  initial begin
    logic [11:0] f;
    bit hit;
    reset_n = 1'b0;
    set_flags('0);
    drive_inputs();

    // Reset holds the FSM in RESET with every output low.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.state", state_dbg, ST_RESET);
    chk("reset.outs", outs, 24'h0);

    // Release: RESET, FETCH, DECODE, ADVANCE with increment_pc.
    @(posedge clk); #1; reset_n = 1'b1;
    @(negedge clk); chk("rel.reset", state_dbg, ST_RESET);
    @(negedge clk); chk("rel.fetch", state_dbg, ST_FETCH);
    @(negedge clk); chk("rel.decode", state_dbg, ST_DECODE);
    @(negedge clk); chk("rel.advance", state_dbg, ST_ADVANCE);
    chk("rel.incpc", increment_pc, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) run_instr("nop", 12'h000, 1'b0, 0, 1);

    // Conditional branch taken then not taken.
    run_instr("brz_taken", 12'h002, 1'b1, 0, 1);
    run_instr("brz_not", 12'h002, 1'b0, 0, 1);
    run_instr("br", 12'h001, 1'b0, 0, 1);

    // Moves: forward 3, backward 2, zero; pause of 10 enable cycles.
    run_instr("mov_p3", 12'h004, 1'b0, 3, 4);
    run_instr("mov_m2", 12'h004, 1'b0, -2, 3);
    run_instr("mov_0", 12'h004, 1'b0, 0, 2);
    run_instr("pause", 12'h008, 1'b0, 0, 11);

    // Every ALU-class instruction once, then priority with mixed flags.
    for (int i = 4; i < 12; i++) begin
      f = '0; f[i] = 1'b1;
      run_instr("alu", f, 1'b0, 0, 1);
    end
    run_instr("prio_mov_pause", 12'h00C, 1'b0, 1, 2);
    run_instr("prio_addi_clr", 12'h110, 1'b0, 0, 1);

    // Random instruction stream.
    for (int i = 0; i < 40; i++) begin
      for (int b = 0; b < 12; b++) f[b] = ($urandom_range(0, 5) == 0);
      run_instr("rand", f, 1'($urandom_range(0, 1)), int'($urandom_range(0, 6)) - 3,
                int'($urandom_range(1, 5)));
    end

    // Reset asserted in the middle of a move wait.
    set_flags(12'h004); tload = 3; dly_len = 6; drive_inputs();
    hit = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(negedge clk);
      if (state_dbg == ST_MOV_WAIT) hit = 1'b1;
      else begin
        model_update();
        @(posedge clk); #1; drive_inputs();
      end
    end
    chk("midmov.reached", hit, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("midmov.state", state_dbg, ST_RESET);
    chk("midmov.outs", outs, 24'h0);
    set_flags('0); temp = 0; dly_cnt = 0; drive_inputs();
    @(posedge clk); @(posedge clk); #1;
    chk("midmov.held", outs, 24'h0);
    reset_n = 1'b1;
    @(negedge clk); chk("midmov.rel", state_dbg, ST_RESET);
    @(posedge clk); #1;
    run_instr("post_reset", 12'h000, 1'b0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, meaning the number of wait cycles after a PC change before the decode flags are valid (synchronous instruction ROM).
REQ-002 SHALL have parameter STEP_SIGNED, default 1, meaning the mov step count is two's-complement (1) or unsigned forward-only (0).
REQ-003 SHALL have port clk, input, 1, system clock.
REQ-004 SHALL have port reset_n, input, 1, reset; one clock, reset asynchronous active-low.
REQ-005 SHALL have port br, brz, addi, subi, sr0, srh0, clr, mov, mova, movr, movrhs, pause: input, 1 each, decoded instruction flags.
REQ-006 SHALL have port delay_done, temp_is_positive, temp_is_negative, temp_is_zero, register0_is_zero: input, 1 each, datapath status.
REQ-007 SHALL have port write_reg_file, result_mux_select, start_delay_counter, enable_delay_counter, commit_branch, increment_pc, alu_add_sub, alu_set_low, alu_set_high, load_temp, increment_temp, decrement_temp: output, 1 each, datapath controls.
REQ-008 SHALL have port op1_mux_select, op2_mux_select, select_immediate, select_write_address: output, 2 each, mux selects.
REQ-009 SHALL have port state_dbg, output, 4, current state encoding.

Function
REQ-010 SHALL be a Moore FSM with states RESET, FETCH, DECODE, BRANCH, BRZ, ALU_OP, MOV_LOAD, MOV_STEP, MOV_WAIT, PAUSE_START, PAUSE_WAIT, ADVANCE; outputs are 0 in any state not listed.
REQ-011 RESET SHALL go to FETCH on the next clock.
REQ-012 FETCH SHALL hold for SETTLE_CYCLES cycles, then go to DECODE.
REQ-013 DECODE SHALL dispatch by fixed priority br > brz > mov > pause > addi > subi > sr0 > srh0 > clr > mova > movr > movrhs.
REQ-014 With no flag set, DECODE SHALL go to ADVANCE (NOP).
REQ-015 BRANCH SHALL assert commit_branch, with op1 = OP1_PC, op2 = OP2_IMM, select_immediate = IMM_BRANCH and alu_add_sub = add, then go to FETCH; increment_pc SHALL stay 0.
REQ-016 BRZ SHALL behave as BRANCH when register0_is_zero = 1, else go to ADVANCE.
REQ-017 ALU_OP SHALL assert write_reg_file for exactly 1 cycle, then go to ADVANCE.
REQ-018 ALU_OP settings per instruction:
- addi/subi: op1 = OP1_REG, op2 = OP2_IMM, add/sub, WA_FIELD1.
- sr0/srh0: alu_set_low/alu_set_high, OP2_IMM, WA_R0.
- clr: set_low and set_high, IMM_ZERO, WA_FIELD0.
- mova/movr/movrhs: op1 = OP1_R0/OP1_REG/OP1_POS, op2 = OP2_ZERO, add, WA_FIELD0/WA_FIELD0/WA_FIELD1.
REQ-019 MOV_LOAD SHALL assert load_temp for 1 cycle, then go to MOV_STEP.
REQ-020 MOV_STEP, when temp_is_zero = 1, SHALL go to ADVANCE.
REQ-021 MOV_STEP, when temp_is_zero = 0, SHALL write position: op1 = OP1_POS, op2 = OP2_ONE, WA_POS.
- temp positive: add and decrement_temp.
- temp negative and STEP_SIGNED = 1: sub and increment_temp.
- STEP_SIGNED = 0: treat temp as positive.
REQ-022 MOV_STEP SHALL assert start_delay_counter in the same cycle, then go to MOV_WAIT.
REQ-023 MOV_WAIT SHALL assert enable_delay_counter until delay_done = 1, then go to MOV_STEP; delay_done sampled outside MOV_WAIT/PAUSE_WAIT SHALL be ignored.
REQ-024 PAUSE_START SHALL assert start_delay_counter; PAUSE_WAIT SHALL behave as MOV_WAIT, exiting to ADVANCE.
REQ-025 ADVANCE SHALL assert increment_pc for 1 cycle, then go to FETCH; PC wrap 255 -> 0 is permitted.
REQ-026 Per executed instruction, at most one of commit_branch/increment_pc SHALL be asserted, exactly once.

Reset
REQ-027 reset_n low SHALL force RESET immediately, including mid-mov or mid-pause, with all outputs 0 while low.
REQ-028 The first FETCH SHALL occur one clock after reset_n rises.

Structure
REQ-029 Package control_pkg SHALL hold the state enum and the encodings:
- OP1_PC = 0, OP1_REG = 1, OP1_R0 = 2, OP1_POS = 3.
- OP2_REG = 0, OP2_IMM = 1, OP2_ONE = 2, OP2_ZERO = 3.
- IMM_BRANCH = 0, IMM_ARITH = 1, IMM_NIBBLE = 2, IMM_ZERO = 3.
- WA_FIELD0 = 0, WA_FIELD1 = 1, WA_POS = 2, WA_R0 = 3.
REQ-030 SHALL contain one sub-module, settle_timer (FETCH wait counter); output decode SHALL be a single case on state.

Verification
REQ-031 Reset release, flags 0 -> RESET, FETCH, DECODE, ADVANCE; increment_pc pulses every 3 cycles (SETTLE_CYCLES = 1).
REQ-032 brz with register0_is_zero = 1, then = 0 -> commit_branch = 1 once with increment_pc = 0; then increment_pc = 1 once with commit_branch = 0.
REQ-033 mov with temp model loaded to 3 and delay_done 4 cycles after each start -> 3 position writes (add), 3 decrement_temp, then ADVANCE.
REQ-034 mov with temp -2 -> 2 sub writes with increment_temp; temp 0 -> no position write.
REQ-035 pause with delay_done held 0 for 10 cycles, then 1 -> enable_delay_counter high 10 cycles, then increment_pc.
REQ-036 reset_n low during MOV_WAIT -> all outputs 0 in the same cycle; FETCH one clock after release.
